// File: rtl/scope_capture.sv
// scope_capture: triggered sample-capture stage between the ADC reader and the
// VGA waveform renderer. Samples are written into one of two ping-pong banks.
// A level/slope trigger stops the capture once the window holds PRETRIG
// samples of history and DEPTH-PRETRIG samples from the trigger onward. The
// renderer reads the other bank. Banks swap only on frame_start_i, so the
// display never changes mid-frame.
//
// Optional feature: define SCOPE_AUTO_TRIG_EN to force a trigger after
// AUTO_TIMEOUT armed samples without a real trigger. auto_trig_o then shows
// that the displayed bank came from a forced trigger. When the macro is
// undefined, auto_trig_o is tied low and the AUTO_TIMEOUT parameter is absent.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   smp_valid_i      one-cycle strobe, smp_data_i holds a new sample
//   smp_data_i[7:0]  unsigned ADC sample
//   trig_level_i     trigger threshold (unsigned)
//   trig_rising_i    1 = rising-slope trigger, 0 = falling-slope trigger
//   frame_start_i    pulse at start of vertical blanking (swap opportunity)
//   rd_addr_i[9:0]   pixel column to read
//   rd_data_o[7:0]   registered sample for rd_addr_i (one cycle latency)
//   cap_state_o      FILL=0, ARMED=1, POST=2, DONE=3
//   swap_o           one-cycle pulse after a bank swap
//   auto_trig_o      displayed bank was captured by a forced trigger
module scope_capture #(
  parameter int DEPTH   = 640,
  parameter int PRETRIG = 64
`ifdef SCOPE_AUTO_TRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 50000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       smp_valid_i,
  input  logic [7:0] smp_data_i,
  input  logic [7:0] trig_level_i,
  input  logic       trig_rising_i,
  input  logic       frame_start_i,
  input  logic [9:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic [1:0] cap_state_o,
  output logic       swap_o,
  output logic       auto_trig_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NPOST = DEPTH - PRETRIG - 1;  // writes after the trigger sample

  localparam logic [AW-1:0] DEPTH_M1  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_W     = AW'(PRETRIG);
  localparam logic [AW-1:0] PRE_M1    = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] DPRE_W    = AW'(DEPTH - PRETRIG);
  localparam logic [AW-1:0] POST_LAST = AW'((NPOST > 0) ? NPOST - 1 : 0);
  localparam logic [10:0]   DEPTH_11  = 11'(DEPTH);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   fill_cnt_q;
  logic [AW-1:0]   post_cnt_q;
  logic [AW-1:0]   trig_ptr_q;
  logic [AW-1:0]   disp_start_q;
  logic [7:0]      prev_q;
  logic            wr_bank_q;
  logic            swap_q;
  logic [7:0]      rd_data_q;

  logic            hit_s;
  logic            trig_s;
  logic [AW-1:0]   wr_ptr_d;
  logic [AW-1:0]   disp_start_d;
  logic [10:0]     rd_sum_s;
  logic [AW-1:0]   rd_idx_s;
  logic            rd_oob_s;

  // Two banks; no reset so the arrays can map onto block RAM.
  logic [7:0]      mem_q [2][DEPTH];

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int ATW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ATW-1:0] AUTO_LAST = ATW'(AUTO_TIMEOUT - 1);

  logic [ATW-1:0]  auto_cnt_q;
  logic            pend_q;     // pending capture was forced
  logic            auto_trig_q;
`endif

  // Slope trigger against the previous accepted sample.
  always_comb begin
    hit_s = 1'b0;
    if (!smp_valid_i) begin
      hit_s = 1'b0;
    end else if (trig_rising_i) begin
      hit_s = (prev_q < trig_level_i) && (smp_data_i >= trig_level_i);
    end else begin
      hit_s = (prev_q >= trig_level_i) && (smp_data_i < trig_level_i);
    end
  end

  // Effective trigger: real hit, or the armed timeout when the feature is built.
  always_comb begin
    trig_s = hit_s;
`ifdef SCOPE_AUTO_TRIG_EN
    if (smp_valid_i && (auto_cnt_q == AUTO_LAST)) begin
      trig_s = 1'b1;
    end else begin
      trig_s = hit_s;
    end
`endif
  end

  // Circular write pointer increment and window start (trig_ptr - PRETRIG mod DEPTH).
  always_comb begin
    wr_ptr_d     = (wr_ptr_q == DEPTH_M1) ? '0 : wr_ptr_q + AW'(1);
    disp_start_d = '0;
    if (trig_ptr_q >= PRE_W) begin
      disp_start_d = trig_ptr_q - PRE_W;
    end else begin
      disp_start_d = trig_ptr_q + DPRE_W;
    end
  end

  // Read address: column offset from the window start, folded back into range.
  always_comb begin
    rd_sum_s = {1'b0, rd_addr_i} + {{(11 - AW){1'b0}}, disp_start_q};
    rd_oob_s = ({1'b0, rd_addr_i} >= DEPTH_11);
    rd_idx_s = '0;
    if (rd_sum_s >= DEPTH_11) begin
      rd_idx_s = AW'(rd_sum_s - DEPTH_11);
    end else begin
      rd_idx_s = AW'(rd_sum_s);
    end
  end

  // Sample write into the capture bank; DONE freezes the bank.
  always_ff @(posedge clk) begin
    if (smp_valid_i && (state_q != DONE)) begin
      mem_q[wr_bank_q][wr_ptr_q] <= smp_data_i;
    end
  end

  // Registered read from the display bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_oob_s ? 8'h00 : mem_q[~wr_bank_q][rd_idx_s];
    end
  end

  // Capture FSM with pointers, counters and bank swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      post_cnt_q   <= '0;
      trig_ptr_q   <= '0;
      disp_start_q <= '0;
      prev_q       <= 8'h00;
      wr_bank_q    <= 1'b0;
      swap_q       <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
      auto_cnt_q   <= '0;
      pend_q       <= 1'b0;
      auto_trig_q  <= 1'b0;
`endif
    end else begin
      swap_q <= 1'b0;
      if (smp_valid_i) begin
        prev_q <= smp_data_i;
      end
      case (state_q)
        FILL: begin
          if (smp_valid_i) begin
            wr_ptr_q <= wr_ptr_d;
            if (fill_cnt_q == PRE_M1) begin
              state_q    <= ARMED;
              fill_cnt_q <= '0;
`ifdef SCOPE_AUTO_TRIG_EN
              auto_cnt_q <= '0;
`endif
            end else begin
              fill_cnt_q <= fill_cnt_q + AW'(1);
            end
          end
        end
        ARMED: begin
          if (smp_valid_i) begin
            wr_ptr_q <= wr_ptr_d;
            if (trig_s) begin
              trig_ptr_q <= wr_ptr_q;  // trigger sample is written at this address
              post_cnt_q <= '0;
`ifdef SCOPE_AUTO_TRIG_EN
              pend_q     <= ~hit_s;
`endif
              if (NPOST > 0) begin
                state_q <= POST;
              end else begin
                state_q <= DONE;
              end
            end else begin
`ifdef SCOPE_AUTO_TRIG_EN
              auto_cnt_q <= auto_cnt_q + ATW'(1);
`endif
            end
          end
        end
        POST: begin
          if (smp_valid_i) begin
            wr_ptr_q <= wr_ptr_d;
            if (post_cnt_q == POST_LAST) begin
              state_q <= DONE;
            end else begin
              post_cnt_q <= post_cnt_q + AW'(1);
            end
          end
        end
        DONE: begin
          if (frame_start_i) begin
            wr_bank_q    <= ~wr_bank_q;
            disp_start_q <= disp_start_d;
            swap_q       <= 1'b1;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            state_q      <= FILL;
`ifdef SCOPE_AUTO_TRIG_EN
            auto_trig_q  <= pend_q;
`endif
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign rd_data_o   = rd_data_q;
  assign cap_state_o = state_q;
  assign swap_o      = swap_q;
`ifdef SCOPE_AUTO_TRIG_EN
  assign auto_trig_o = auto_trig_q;
`else
  assign auto_trig_o = 1'b0;
`endif

endmodule

// File: tb/tb_scope_capture.sv
// Directed self-checking bench for scope_capture with DEPTH=16, PRETRIG=4,
// trigger level 0x80 (and AUTO_TIMEOUT=32 when SCOPE_AUTO_TRIG_EN is defined).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_scope_capture;

  logic       clk;
  logic       rst;
  logic       smp_valid;
  logic [7:0] smp_data;
  logic [7:0] trig_level;
  logic       trig_rising;
  logic       frame_start;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic [1:0] cap_state;
  logic       swap;
  logic       auto_trig;

  int n_tests = 0;
  int n_fail  = 0;

  scope_capture #(
    .DEPTH(16),
    .PRETRIG(4)
`ifdef SCOPE_AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT(32)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .smp_valid_i  (smp_valid),
    .smp_data_i   (smp_data),
    .trig_level_i (trig_level),
    .trig_rising_i(trig_rising),
    .frame_start_i(frame_start),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .cap_state_o  (cap_state),
    .swap_o       (swap),
    .auto_trig_o  (auto_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample per cycle, optionally with frame_start in the same cycle.
  task automatic send(input logic [7:0] d, input logic fs);
    smp_valid   = 1'b1;
    smp_data    = d;
    frame_start = fs;
    @(negedge clk);
    smp_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic rd(input string tag, input int col, input logic [7:0] exp);
    rd_addr = col[9:0];
    @(negedge clk);
    check(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  logic [7:0] v;
  logic [7:0] exp_b;
  logic [7:0] tbl3 [16];

  initial begin
    rst = 1'b1; smp_valid = 1'b0; smp_data = 8'h00; trig_level = 8'h80;
    trig_rising = 1'b1; frame_start = 1'b0; rd_addr = 10'd0;
    tbl3 = '{8'h81, 8'h82, 8'h90, 8'h10, 8'h80, 8'hA1, 8'hA2, 8'hA3,
             8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA, 8'hAB};
    @(negedge clk); @(negedge clk);
    check("rst_state", {30'h0, cap_state}, 32'd0);
    check("rst_swap", {31'h0, swap}, 32'd0);
    check("rst_auto", {31'h0, auto_trig}, 32'd0);
    check("rst_rdata", {24'h0, rd_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Rising ramp 0x70..0x9F: trigger 0x80 wraps wr_ptr to 0 in ARMED.
    for (int i = 8'h70; i <= 8'h9F; i++) begin
      v = i[7:0];
      send(v, 1'b0);
      if (v == 8'h7F) check("rise_armed", {30'h0, cap_state}, 32'd1);
      if (v == 8'h80) check("rise_post", {30'h0, cap_state}, 32'd2);
    end
    check("rise_done", {30'h0, cap_state}, 32'd3);
    frame();
    check("rise_swap", {31'h0, swap}, 32'd1);
    check("rise_fill", {30'h0, cap_state}, 32'd0);
    for (int c = 0; c < 16; c++) begin
      exp_b = 8'h7C + 8'(c);
      rd("rise_col", c, exp_b);
      if (c == 0) check("swap_one_cycle", {31'h0, swap}, 32'd0);
    end
    check("rise_auto", {31'h0, auto_trig}, 32'd0);

    // Falling ramp 0x90..0x60: column 4 is 0x7F.
    trig_rising = 1'b0;
    for (int i = 8'h90; i >= 8'h60; i--) begin
      v = i[7:0];
      send(v, 1'b0);
    end
    check("fall_done", {30'h0, cap_state}, 32'd3);
    frame();
    check("fall_swap", {31'h0, swap}, 32'd1);
    for (int c = 0; c < 16; c++) begin
      exp_b = 8'h83 - 8'(c);
      rd("fall_col", c, exp_b);
    end

    // Crossing during FILL is ignored; frame_start in POST and on final POST write.
    trig_rising = 1'b1;
    send(8'h7F, 1'b0);
    send(8'h80, 1'b0);
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    check("fillx_armed", {30'h0, cap_state}, 32'd1);
    send(8'h90, 1'b0);
    send(8'h10, 1'b0);
    check("fillx_still_armed", {30'h0, cap_state}, 32'd1);
    send(8'h80, 1'b0);
    check("fillx_post", {30'h0, cap_state}, 32'd2);
    for (int k = 1; k <= 5; k++) send(8'hA0 + 8'(k), 1'b0);
    frame();
    check("post_fs_noswap", {31'h0, swap}, 32'd0);
    check("post_fs_state", {30'h0, cap_state}, 32'd2);
    for (int k = 6; k <= 10; k++) send(8'hA0 + 8'(k), 1'b0);
    send(8'hAB, 1'b1);
    check("coinc_done", {30'h0, cap_state}, 32'd3);
    check("coinc_noswap", {31'h0, swap}, 32'd0);
    @(negedge clk);
    check("coinc_noswap2", {31'h0, swap}, 32'd0);
    frame();
    check("done_fs_swap", {31'h0, swap}, 32'd1);
    for (int c = 0; c < 16; c++) rd("fillx_col", c, tbl3[c]);
    rd("rd_oob20", 20, 8'h00);
    rd("rd_oob16", 16, 8'h00);
    rd("rd_last15", 15, 8'hAB);

`ifdef SCOPE_AUTO_TRIG_EN
    // Constant 0x10: forced trigger after 32 armed samples, DONE 11 later.
    for (int k = 0; k < 46; k++) send(8'h10, 1'b0);
    check("auto_post", {30'h0, cap_state}, 32'd2);
    send(8'h10, 1'b0);
    check("auto_done", {30'h0, cap_state}, 32'd3);
    frame();
    check("auto_swap", {31'h0, swap}, 32'd1);
    check("auto_flag", {31'h0, auto_trig}, 32'd1);
    rd("auto_col0", 0, 8'h10);
    rd("auto_col15", 15, 8'h10);
    for (int k = 0; k < 39; k++) send(8'h10, 1'b0);
`else
    // Constant 0x10 never triggers: ARMED holds indefinitely.
    for (int k = 0; k < 47; k++) send(8'h10, 1'b0);
    check("noauto_armed", {30'h0, cap_state}, 32'd1);
    check("noauto_flag", {31'h0, auto_trig}, 32'd0);
    send(8'h90, 1'b0);
    for (int k = 0; k < 3; k++) send(8'h91, 1'b0);
`endif

    // Reset mid-POST abandons the capture.
    check("pre_rst_post", {30'h0, cap_state}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", {30'h0, cap_state}, 32'd0);
    check("midrst_swap", {31'h0, swap}, 32'd0);
    check("midrst_auto", {31'h0, auto_trig}, 32'd0);
    check("midrst_rdata", {24'h0, rd_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    frame();
    check("after_rst_noswap", {31'h0, swap}, 32'd0);
    check("after_rst_fill", {30'h0, cap_state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
# scope_capture

Triggered sample-capture stage between the ADC read interface and the VGA waveform renderer. It accepts one 8-bit sample per `smp_valid` strobe and detects a level/slope trigger. It stores a `DEPTH`-sample window with `PRETRIG` samples of pre-trigger history into ping-pong banks. The renderer reads one stable bank per pixel column, and banks swap only at frame start, so the display never tears mid-frame.

## Interface
- `DEPTH`, 640, samples per capture window; one per visible pixel column.
- `PRETRIG`, 64, samples shown before the trigger point; must satisfy `1 <= PRETRIG < DEPTH`.
- `AUTO_TIMEOUT`, 50000, armed samples without a trigger before a forced trigger; used only with `SCOPE_AUTO_TRIG_EN`.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `smp_valid`  in  1  one-cycle strobe: `smp_data` holds a new ADC sample.
- `smp_data`  in  8  ADC sample, unsigned.
- `trig_level`  in  8  trigger threshold, unsigned.
- `trig_rising`  in  1  1 = rising-slope trigger, 0 = falling-slope trigger.
- `frame_start`  in  1  one-cycle pulse from VGA timing at the start of vertical blanking.
- `rd_addr`  in  10  pixel column to read.
- `rd_data`  out  8  sample for `rd_addr`, registered.
- `cap_state`  out  2  current FSM state: FILL=0, ARMED=1, POST=2, DONE=3.
- `swap`  out  1  one-cycle pulse on a bank swap.
- `auto_trig`  out  1  1 = displayed bank was captured by a forced (auto) trigger.

## Operation
- Memory: 2 banks × `DEPTH` × 8 bits, synchronous write and synchronous read.
  - `wr_bank` receives writes; `disp_bank` = `~wr_bank` is read.
  - Memory is not reset.
- `prev`: last accepted sample, 8 bits. Updated on every `smp_valid` in every state.
- Trigger condition `hit`, evaluated only on `smp_valid`:
  - Rising: `prev < trig_level && smp_data >= trig_level`.
  - Falling: `prev >= trig_level && smp_data < trig_level`.
- Write rule: in FILL, ARMED and POST, each `smp_valid` writes `smp_data` to `wr_bank[wr_ptr]`, then `wr_ptr` advances modulo `DEPTH` (`DEPTH-1` wraps to 0). DONE performs no writes.
- FILL:
  - Count writes.
  - After the `PRETRIG`-th write, go to ARMED.
  - `hit` is ignored in FILL.
- ARMED:
  - Circular writes continue.
  - On `hit`: set `trig_ptr` = address of the hitting sample, which is itself written; clear `post_cnt`; go to POST.
- POST:
  - Count writes after the trigger sample.
  - When the (`DEPTH-PRETRIG-1`)-th post write completes, go to DONE.
  - Result: the trigger sample appears at display column `PRETRIG`.
- DONE: hold until `frame_start`. Then, at that edge:
  - Toggle `wr_bank`.
  - Set `disp_start` = (`trig_ptr - PRETRIG`) mod `DEPTH`.
  - Latch `auto_trig` from the pending-capture flag.
  - Pulse `swap`.
  - Clear `wr_ptr` and the fill counter; go to FILL.
- `frame_start` outside DONE has no effect; the display keeps the previous bank.
- Read rule:
  - Address = (`disp_start + rd_addr`) computed 11 bits wide, minus `DEPTH` if the sum is `>= DEPTH`.
  - If `rd_addr >= DEPTH`, the next `rd_data` is 0.
- Reset values:
  - State FILL; `wr_ptr`, fill and post counters 0; `prev` 0; `trig_ptr` 0; `disp_start` 0.
  - `wr_bank` 0; `rd_data` 0; `swap` 0; `auto_trig` 0.
  - Display contents before the first swap are undefined.
- Reset mid-operation: the capture is abandoned, all state returns to reset values, and no swap occurs.

## Timing
- `hit` is combinational on `smp_data` and registered `prev`. The state transition, write and `trig_ptr` capture all occur on the same edge that accepts the sample.
- `rd_data` is valid 1 clk after `rd_addr`, which is pipeline-compatible with a 25 MHz pixel enable.
- `swap` is high for exactly the cycle after the `frame_start` edge that performed the swap.
- If `frame_start` coincides with the final POST write, state becomes DONE and no swap occurs; the swap happens at the next `frame_start`.
- `smp_valid` may assert on consecutive cycles; the block takes no back-pressure.

## Configuration
- `SCOPE_AUTO_TRIG_EN` defined:
  - An ARMED-state counter increments per `smp_valid` and clears on entry to ARMED.
  - When the count reaches `AUTO_TIMEOUT` with no `hit`, that sample is treated as a trigger and the pending-capture flag is set to 1.
  - A real `hit` sets the pending-capture flag to 0.
- `SCOPE_AUTO_TRIG_EN` undefined:
  - No auto counter exists.
  - ARMED waits indefinitely for `hit`.
  - `auto_trig` is tied to 0.

## Test plan
- Bench parameters: `DEPTH`=16, `PRETRIG`=4, `trig_level`=8'h80, rising.
  - Stimulus: ramp samples 0x70..0x9F, then pulse `frame_start`.
  - Response: `swap` pulses; `rd_addr` 0..15 return 0x7C..0x8B; column 4 = 0x80.
- Falling slope (`trig_rising`=0), with a descending ramp 0x90..0x60:
  - Response: column 4 = 0x7F, the first sample below the threshold.
- Crossing during FILL: 0x7F then 0x80 as samples 1–2 of FILL.
  - Response: no trigger; the FSM stays ARMED until the next crossing.
- Back-to-back `smp_valid` with a wrap of `wr_ptr` in ARMED before the trigger:
  - Response: read data is contiguous across the wrap and `disp_start` is correct modulo 16.
- `frame_start` in POST, then again in DONE:
  - Response: no swap on the first; swap on the second.
  - Also drive `rd_addr`=20: response `rd_data`=0.
- With `SCOPE_AUTO_TRIG_EN` and `AUTO_TIMEOUT`=32, feed constant 0x10:
  - Response: DONE after 32+11 armed samples; after swap, `auto_trig`=1.
  - Assert `rst` mid-POST: response all outputs at reset values, `cap_state`=0.
